// File: rtl/bcd_conv_pkg.sv
// Purpose: shared types and constants for the BCD-to-binary converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_conv_pkg;

  // Converter control states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int BCD_DIGIT_W   = 4;
  localparam int BCD_MAX_DIGIT = 9;

  // Smallest binary width able to hold 10^num_digits - 1.
  function automatic int bcd_min_bin_width(input int num_digits);
    longint unsigned max_plus_one;
    max_plus_one = 64'd1;
    for (int i = 0; i < num_digits; i++) begin
      max_plus_one = max_plus_one * 64'd10;
    end
    return int'($clog2(max_plus_one));
  endfunction

endpackage

// File: rtl/mul10_add.sv
// Purpose: combinational multiply-by-ten plus one BCD digit (one Horner step).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module mul10_add
  import bcd_conv_pkg::*;
#(
  parameter int W = 14
) (
  input  logic [W-1:0]           i_acc,
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [W-1:0]           o_value
);

  // Four guard bits keep the shift-add exact before narrowing back to W;
  // the width check in the parent guarantees the narrowing loses nothing.
  logic [W+3:0] w_acc_ext;
  logic [W+3:0] w_digit_ext;

  assign w_acc_ext   = {4'b0000, i_acc};
  assign w_digit_ext = {{W{1'b0}}, i_digit};

  // acc*10 as acc*8 + acc*2, then add the incoming digit.
  assign o_value = W'((w_acc_ext << 3) + (w_acc_ext << 1) + w_digit_ext);

endmodule

// File: rtl/bcd_to_binary_converter.sv
// Purpose: packed multi-digit BCD to unsigned binary, Horner order, MSD first.
// Latency: done NUM_DIGITS+1 cycles after start (1 cycle when a digit is invalid).
// Backpressure: start is sampled only in IDLE; requests while busy are dropped.
module bcd_to_binary_converter
  import bcd_conv_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 14
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sync_clr,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] bcd_in,
  output logic                          busy,
  output logic                          done,
  output logic                          digit_error,
  output logic [BIN_WIDTH-1:0]          binary_value
);

  localparam int DW = BCD_DIGIT_W * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_DIGITS - 1);
  localparam logic [BCD_DIGIT_W-1:0] MAX_DIGIT = BCD_DIGIT_W'(BCD_MAX_DIGIT);

  // The accumulator must never wrap for the largest decimal input.
  if (BIN_WIDTH < bcd_min_bin_width(NUM_DIGITS)) begin : g_width_check
    $error("BIN_WIDTH too small to hold 10^NUM_DIGITS - 1");
  end

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [DW-1:0]          r_shift;
  logic [BIN_WIDTH-1:0]   r_acc;
  logic [BIN_WIDTH-1:0]   r_bin;
  logic [CW-1:0]          r_cnt;
  logic                   r_err;
  logic                   w_bad_digit;
  logic                   w_accept;
  logic                   w_last;
  logic [BIN_WIDTH-1:0]   w_mac;

  // Flag any nibble of the live input that is not a decimal digit.
  always_comb begin
    w_bad_digit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] > MAX_DIGIT) begin
        w_bad_digit = 1'b1;
      end
    end
  end

  assign w_last = (r_cnt == LAST_CNT);

  // One Horner step on the most significant remaining digit.
  mul10_add #(
    .W (BIN_WIDTH)
  ) u_mul10_add (
    .i_acc   (r_acc),
    .i_digit (r_shift[DW-1 -: BCD_DIGIT_W]),
    .o_value (w_mac)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and decoded status outputs; sync_clr overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_bad_digit ? DONE : CONVERT;
        end
      end
      CONVERT: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (sync_clr) begin
      w_state_nxt = IDLE;
      w_accept    = 1'b0;
    end
  end

  // Capture digits on accept, then accumulate one digit per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_bin   <= '0;
    end else if (sync_clr) begin
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_bin   <= '0;
    end else if (w_accept) begin
      // Invalid input skips conversion, so the result reads as zero.
      r_shift <= bcd_in;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_err   <= w_bad_digit;
      r_bin   <= '0;
    end else if (r_state == CONVERT) begin
      r_acc   <= w_mac;
      r_shift <= r_shift << BCD_DIGIT_W;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_bin <= w_mac;
      end
    end
  end

  assign digit_error  = r_err;
  assign binary_value = r_bin;

endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// Purpose: directed self-checking bench for bcd_to_binary_converter.
// Latency: checks done timing of 5 cycles (valid) and 1 cycle (invalid digits).
// Backpressure: exercises start held high while busy and mid-conversion aborts.
module tb_bcd_to_binary_converter;

  logic        clk;
  logic        reset_n;
  logic        sync_clr;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic        digit_error;
  logic [13:0] binary_value;

  int n_vec;
  int n_err;

  bcd_to_binary_converter #(
    .NUM_DIGITS (4),
    .BIN_WIDTH  (14)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sync_clr     (sync_clr),
    .start        (start),
    .bcd_in       (bcd_in),
    .busy         (busy),
    .done         (done),
    .digit_error  (digit_error),
    .binary_value (binary_value)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".err"},  32'(digit_error), 32'd0);
    check({tag, ".val"},  32'(binary_value), 32'd0);
  endtask

  // Decimal to packed BCD, digit by digit.
  function automatic logic [15:0] to_bcd(input int dec);
    logic [15:0] r;
    int d;
    r = 16'h0;
    d = dec;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return r;
  endfunction

  // Issue one start pulse, then measure latency and check the result.
  task automatic run_conv(input string tag, input logic [15:0] bcd,
                          input int exp_val, input logic exp_err, input int exp_lat);
    int lat;
    @(negedge clk);
    bcd_in = bcd;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 16'hFFFF;
    check({tag, ".busy_rise"}, 32'(busy), 32'd1);
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".value"}, 32'(binary_value), 32'(exp_val));
    check({tag, ".digit_error"}, 32'(digit_error), 32'(exp_err));
    @(negedge clk);
    check({tag, ".done_width"}, 32'(done), 32'd0);
    check({tag, ".busy_fall"}, 32'(busy), 32'd0);
  endtask

  int hs_dec [19];
  int n_done;

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset_n  = 1'b0;
    sync_clr = 1'b0;
    start    = 1'b0;
    bcd_in   = 16'h0;

    // Reset held for three cycles, then idle with start low.
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_zero("idle");

    // Main conversions and boundaries.
    run_conv("conv1234", 16'h1234, 1234, 1'b0, 5);
    run_conv("conv9999", 16'h9999, 9999, 1'b0, 5);
    run_conv("conv0000", 16'h0000, 0,    1'b0, 5);
    run_conv("conv0007", 16'h0007, 7,    1'b0, 5);

    // Invalid digit then a clean recovery.
    run_conv("bad12A4",  16'h12A4, 0,    1'b1, 1);
    run_conv("conv0042", 16'h0042, 42,   1'b0, 5);

    // start held high with bcd_in changing every cycle: accept at 0, 6, 12.
    for (int c = 0; c < 19; c++) hs_dec[c] = 1000 + 111 * c;
    n_done = 0;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        check("hs.done_slot", 32'(done), (c % 6 == 5) ? 32'd1 : 32'd0);
        if (done === 1'b1) begin
          n_done++;
          check("hs.value", 32'(binary_value), 32'(hs_dec[c - 5]));
        end
      end
      if (c < 18) begin
        start  = 1'b1;
        bcd_in = to_bcd(hs_dec[c]);
      end else begin
        start  = 1'b0;
      end
    end
    check("hs.done_count", 32'(n_done), 32'd3);
    repeat (8) @(negedge clk);
    check("hs.settle_busy", 32'(busy), 32'd0);

    // sync_clr during the second CONVERT cycle.
    run_conv("pre_clr", 16'h0042, 42, 1'b0, 5);
    @(negedge clk);
    bcd_in = 16'h5678;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    @(negedge clk);
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    check_idle_zero("clr");
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check("clr.no_done", 32'(n_done), 32'd0);

    // Asynchronous reset in the middle of a conversion.
    run_conv("pre_rst", 16'h0042, 42, 1'b0, 5);
    @(negedge clk);
    bcd_in = 16'h5678;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_zero("arst");
    @(negedge clk);
    reset_n = 1'b1;
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check("arst.no_done", 32'(n_done), 32'd0);

    // Converter works normally after the abort.
    run_conv("post_rst", 16'h5678, 5678, 1'b0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
